// File: rtl/payout_eval_pkg.sv
// Shared encodings for round settlement: combination classes, payout multipliers
// and the settlement FSM states, used by payout_eval, the bank and the VGA overlay.
package payout_eval_pkg;

    typedef enum logic [2:0] {
        CLS_NONE     = 3'd0,
        CLS_PAIR     = 3'd1,
        CLS_TWO_PAIR = 3'd2,
        CLS_THREE    = 3'd3,
        CLS_FOUR     = 3'd4,
        CLS_JACKPOT  = 3'd5,
        CLS_INVALID  = 3'd7
    } win_class_t;

    localparam logic [6:0] MULT_NONE     = 7'd0;
    localparam logic [6:0] MULT_PAIR     = 7'd2;
    localparam logic [6:0] MULT_TWO_PAIR = 7'd5;
    localparam logic [6:0] MULT_THREE    = 7'd10;
    localparam logic [6:0] MULT_FOUR     = 7'd50;
    localparam logic [6:0] MULT_JACKPOT  = 7'd100;

    localparam logic [3:0] JACKPOT_DIGIT = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLASSIFY,
        ST_MULT,
        ST_PRESENT
    } state_t;

    // Number of equal digit pairs among the six possible pairings (0,1,2,3 or 6).
    function automatic logic [2:0] count_pairs(input logic [3:0] a, input logic [3:0] b,
                                               input logic [3:0] c, input logic [3:0] d);
        return 3'(a == b) + 3'(a == c) + 3'(a == d)
             + 3'(b == c) + 3'(b == d) + 3'(c == d);
    endfunction

endpackage

// File: rtl/payout_eval_classify.sv
// Combinational classifier: maps four latched reel digits to a combination
// class and its payout multiplier.
module payout_classify
    import payout_eval_pkg::*;
#(
    parameter int MULT_W = 7
) (
    input  logic [3:0]        d1,
    input  logic [3:0]        d2,
    input  logic [3:0]        d3,
    input  logic [3:0]        d4,
    output logic [2:0]        win_class,
    output logic [MULT_W-1:0] mult
);

    logic [2:0] pairs;
    logic       invalid;

    assign pairs   = count_pairs(d1, d2, d3, d4);
    assign invalid = (d1 > 4'd9) || (d2 > 4'd9) || (d3 > 4'd9) || (d4 > 4'd9);

    always_comb begin
        win_class = CLS_NONE;
        mult      = MULT_W'(MULT_NONE);
        if (invalid) begin
            win_class = CLS_INVALID;
            mult      = MULT_W'(MULT_NONE);
        end else begin
            case (pairs)
                3'd6: begin
                    if (d1 == JACKPOT_DIGIT) begin
                        win_class = CLS_JACKPOT;
                        mult      = MULT_W'(MULT_JACKPOT);
                    end else begin
                        win_class = CLS_FOUR;
                        mult      = MULT_W'(MULT_FOUR);
                    end
                end
                3'd3: begin
                    win_class = CLS_THREE;
                    mult      = MULT_W'(MULT_THREE);
                end
                3'd2: begin
                    win_class = CLS_TWO_PAIR;
                    mult      = MULT_W'(MULT_TWO_PAIR);
                end
                3'd1: begin
                    win_class = CLS_PAIR;
                    mult      = MULT_W'(MULT_PAIR);
                end
                default: begin
                    win_class = CLS_NONE;
                    mult      = MULT_W'(MULT_NONE);
                end
            endcase
        end
    end

endmodule

// File: rtl/payout_eval.sv
// Round settlement: freezes reels and bet on stop_pulse, classifies, computes
// bet*multiplier by fixed-length shift-add and hands the result to the bank.
module payout_eval
    import payout_eval_pkg::*;
#(
    parameter int BAL_W  = 16,
    parameter int MULT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stop_pulse,
    input  logic [3:0]       reel1,
    input  logic [3:0]       reel2,
    input  logic [3:0]       reel3,
    input  logic [3:0]       reel4,
    input  logic [BAL_W-1:0] bet,
    input  logic             win_ack,
    output logic             win_valid,
    output logic [BAL_W-1:0] win_amount,
    output logic [2:0]       win_class,
    output logic             busy
);

    localparam int ACC_W = BAL_W + MULT_W;
    localparam int CNT_W = $clog2(MULT_W) + 1;

    state_t state, state_next;

    logic [3:0]        d1, d2, d3, d4;
    logic [ACC_W-1:0]  bet_sh;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_add;
    logic [MULT_W-1:0] mult_sh;
    logic [CNT_W-1:0]  cnt;
    logic              last_iter;
    logic [BAL_W-1:0]  amount_sat;
    logic [2:0]        cls_class;
    logic [MULT_W-1:0] cls_mult;

    payout_classify #(.MULT_W(MULT_W)) u_classify (
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .d4        (d4),
        .win_class (cls_class),
        .mult      (cls_mult)
    );

    assign last_iter  = (cnt == CNT_W'(MULT_W - 1));
    assign acc_add    = mult_sh[0] ? (acc + bet_sh) : acc;
    assign amount_sat = (|acc_add[ACC_W-1:BAL_W]) ? '1 : acc_add[BAL_W-1:0];
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (stop_pulse) state_next = ST_CLASSIFY;
            ST_CLASSIFY: state_next = ST_MULT;
            ST_MULT:     if (last_iter) state_next = ST_PRESENT;
            ST_PRESENT:  if (win_ack) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // The final MULT edge registers the saturated sum including that edge's add.
    always_ff @(posedge clk) begin
        if (!rst) begin
            d1         <= '0;
            d2         <= '0;
            d3         <= '0;
            d4         <= '0;
            bet_sh     <= '0;
            acc        <= '0;
            mult_sh    <= '0;
            cnt        <= '0;
            win_valid  <= 1'b0;
            win_amount <= '0;
            win_class  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (stop_pulse) begin
                        d1     <= reel1;
                        d2     <= reel2;
                        d3     <= reel3;
                        d4     <= reel4;
                        bet_sh <= ACC_W'(bet);
                    end
                end
                ST_CLASSIFY: begin
                    mult_sh <= cls_mult;
                    acc     <= '0;
                    cnt     <= '0;
                end
                ST_MULT: begin
                    acc     <= acc_add;
                    bet_sh  <= bet_sh << 1;
                    mult_sh <= mult_sh >> 1;
                    cnt     <= cnt + 1'b1;
                    if (last_iter) begin
                        win_amount <= amount_sat;
                        win_class  <= cls_class;
                        win_valid  <= 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (win_ack) win_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_payout_eval.sv
// Directed bench for payout_eval: hand-computed payouts, latency, handshake,
// saturation, invalid digits, ignored strobes and mid-round reset.
module tb_payout_eval;

    logic        clk = 1'b0;
    logic        rst;
    logic        stop_pulse;
    logic [3:0]  reel1, reel2, reel3, reel4;
    logic [15:0] bet;
    logic        win_ack;
    logic        win_valid;
    logic [15:0] win_amount;
    logic [2:0]  win_class;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int lat;
    int seen;

    payout_eval #(.BAL_W(16), .MULT_W(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .stop_pulse (stop_pulse),
        .reel1      (reel1),
        .reel2      (reel2),
        .reel3      (reel3),
        .reel4      (reel4),
        .bet        (bet),
        .win_ack    (win_ack),
        .win_valid  (win_valid),
        .win_amount (win_amount),
        .win_class  (win_class),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_round(input logic [3:0] r1, input logic [3:0] r2,
                               input logic [3:0] r3, input logic [3:0] r4,
                               input logic [15:0] b);
        reel1 = r1; reel2 = r2; reel3 = r3; reel4 = r4; bet = b;
        stop_pulse = 1'b1;
        tick();
        stop_pulse = 1'b0;
    endtask

    // Counts edges after the strobe edge until win_valid; 8 is the required latency.
    task automatic wait_valid(output int n);
        n = 0;
        while (!win_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst = 1'b0; stop_pulse = 1'b0; win_ack = 1'b0; bet = '0;
        reel1 = '0; reel2 = '0; reel3 = '0; reel4 = '0;
        tick(); tick();
        check("rst_valid", int'(win_valid), 0);
        check("rst_amount", int'(win_amount), 0);
        check("rst_class", int'(win_class), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b1;
        tick();

        // Jackpot with ack held high: one-cycle valid
        win_ack = 1'b1;
        start_round(4'd7, 4'd7, 4'd7, 4'd7, 16'd10);
        check("jp_busy", int'(busy), 1);
        check("jp_valid_early", int'(win_valid), 0);
        wait_valid(lat);
        check("jp_latency", lat, 8);
        check("jp_class", int'(win_class), 5);
        check("jp_amount", int'(win_amount), 1000);
        tick();
        check("jp_valid_drop", int'(win_valid), 0);
        check("jp_busy_drop", int'(busy), 0);
        win_ack = 1'b0;

        // Two pair with delayed ack: outputs held stable
        start_round(4'd3, 4'd3, 4'd5, 4'd5, 16'd4);
        wait_valid(lat);
        check("tp_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            check("tp_hold_valid", int'(win_valid), 1);
            check("tp_hold_class", int'(win_class), 2);
            check("tp_hold_amount", int'(win_amount), 20);
            check("tp_hold_busy", int'(busy), 1);
            if (i < 4) tick();
        end
        win_ack = 1'b1;
        tick();
        check("tp_valid_drop", int'(win_valid), 0);
        check("tp_busy_drop", int'(busy), 0);
        win_ack = 1'b0;

        // No win still produces a handshake
        win_ack = 1'b1;
        start_round(4'd1, 4'd2, 4'd3, 4'd4, 16'd100);
        wait_valid(lat);
        check("none_latency", lat, 8);
        check("none_class", int'(win_class), 0);
        check("none_amount", int'(win_amount), 0);
        tick();
        check("none_valid_drop", int'(win_valid), 0);

        // Four of a kind, 2000*50 saturates
        start_round(4'd9, 4'd9, 4'd9, 4'd9, 16'd2000);
        wait_valid(lat);
        check("four_class", int'(win_class), 4);
        check("four_amount", int'(win_amount), 65535);
        tick();

        // Invalid digit outranks the three 1s
        start_round(4'd1, 4'd1, 4'd12, 4'd1, 16'd50);
        wait_valid(lat);
        check("inv_class", int'(win_class), 7);
        check("inv_amount", int'(win_amount), 0);
        tick();

        // Pair and three of a kind
        start_round(4'd2, 4'd5, 4'd2, 4'd8, 16'd3);
        wait_valid(lat);
        check("pair_class", int'(win_class), 1);
        check("pair_amount", int'(win_amount), 6);
        tick();
        start_round(4'd4, 4'd4, 4'd4, 4'd0, 16'd7);
        wait_valid(lat);
        check("three_class", int'(win_class), 3);
        check("three_amount", int'(win_amount), 70);
        tick();

        // Jackpot with bet=0 keeps the class
        start_round(4'd7, 4'd7, 4'd7, 4'd7, 16'd0);
        wait_valid(lat);
        check("zero_class", int'(win_class), 5);
        check("zero_amount", int'(win_amount), 0);
        tick();
        win_ack = 1'b0;

        // Second strobe during MULT is ignored; strobe on the ack edge also ignored
        start_round(4'd7, 4'd7, 4'd7, 4'd7, 16'd1);
        tick(); tick(); tick();
        start_round(4'd1, 4'd1, 4'd2, 4'd2, 16'd9);
        wait_valid(lat);
        check("ign_latency", lat, 4);
        check("ign_class", int'(win_class), 5);
        check("ign_amount", int'(win_amount), 100);
        win_ack = 1'b1;
        start_round(4'd1, 4'd1, 4'd2, 4'd2, 16'd9);
        win_ack = 1'b0;
        check("ign_ack_valid", int'(win_valid), 0);
        check("ign_ack_busy", int'(busy), 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (win_valid) seen++;
        end
        check("ign_extra_payouts", seen, 0);

        // Reset in the middle of MULT discards the round
        start_round(4'd5, 4'd5, 4'd6, 4'd6, 16'd8);
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        check("mrst_valid", int'(win_valid), 0);
        check("mrst_busy", int'(busy), 0);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (win_valid || busy) seen++;
        end
        check("mrst_quiet", seen, 0);

        // Fresh round after reset
        win_ack = 1'b1;
        start_round(4'd5, 4'd5, 4'd5, 4'd5, 16'd3);
        wait_valid(lat);
        check("post_latency", lat, 8);
        check("post_class", int'(win_class), 4);
        check("post_amount", int'(win_amount), 150);
        tick();
        check("post_valid_drop", int'(win_valid), 0);
        win_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/payout_eval.md
Name: payout_eval

Overview:
- Round-settlement stage between the reel generator and the bank.
- On the reels-stopped strobe it freezes the four reel digits and the current bet, then classifies the combination.
- It computes the payout as bet × multiplier with a sequential shift-add and presents it to the bank over a valid/ack handshake.
- Every round produces exactly one handshake, including zero-payout rounds, so the bank always sees round completion.

Parameters:
- BAL_W, 16, width of the bet and payout amounts; the payout saturates at 2^BAL_W-1.
- MULT_W, 7, width of the multiplier; holds 100 and sets the number of MULT iterations.

Ports:
- clk  input  1  master clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-low (rst=0 resets on the next rising clk edge).
- stop_pulse  input  1  one-cycle strobe: the reels have stopped and the reel digits are stable.
- reel1  input  4  reel digit 1, valid range 0-9.
- reel2  input  4  reel digit 2, valid range 0-9.
- reel3  input  4  reel digit 3, valid range 0-9.
- reel4  input  4  reel digit 4, valid range 0-9.
- bet  input  BAL_W  current bet amount from the bank; sampled together with the reels.
- win_ack  input  1  bank has consumed win_amount.
- win_valid  output  1  win_amount and win_class are valid; held until acknowledged.
- win_amount  output  BAL_W  payout value.
- win_class  output  3  combination class.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0 at an edge):
  - State goes to IDLE.
  - win_valid=0, win_amount=0, win_class=0, busy=0.
  - Internal latches and the accumulator are cleared.
  - Reset overrides everything, including a reset taken in the middle of a round. That round is discarded and no win_valid is produced.
- States: IDLE, CLASSIFY, MULT, PRESENT.
- IDLE:
  - On stop_pulse=1 at edge N, latch reel1..4 and bet, then go to CLASSIFY.
  - stop_pulse is ignored in every other state; no queuing.
- CLASSIFY (one cycle, edge N+1):
  - Count equal pairs among the 6 digit pairs.
  - Class mapping:
    - any digit >9: INVALID=7, multiplier 0.
    - count 6 with digit 7: JACKPOT=5, multiplier 100.
    - count 6 otherwise: FOUR=4, multiplier 50.
    - count 3: THREE=3, multiplier 10.
    - count 2: TWO_PAIR=2, multiplier 5.
    - count 1: PAIR=1, multiplier 2.
    - count 0: NONE=0, multiplier 0.
  - Load the multiplier shift register and clear the (BAL_W+MULT_W)-bit accumulator, then go to MULT.
- MULT (exactly MULT_W cycles, edges N+2..N+8):
  - Each cycle, if the multiplier LSB is 1, add the shifted bet to the accumulator.
  - Shift the bet left and the multiplier right.
  - The iteration count is fixed; there is no early exit, so latency is constant.
  - At edge N+8: win_amount = the accumulator, saturated to all-ones if any bit above BAL_W-1 is set. win_class is registered, win_valid=1, and the state goes to PRESENT.
- Latency: stop_pulse sampled at edge N → win_valid is high after edge N+8.
- PRESENT:
  - win_valid, win_amount and win_class are held stable until win_ack=1 is sampled.
  - At that edge: win_valid=0, state goes to IDLE, busy=0 after that edge.
  - win_amount and win_class keep their last values after ack; they are don't-care for the bank.
- Handshake rules:
  - win_ack is ignored whenever win_valid=0.
  - win_ack that is already high on the first PRESENT cycle completes the transfer in that cycle (one-cycle valid).
  - stop_pulse arriving in the same cycle as the ack edge is ignored; a new round requires stop_pulse while in IDLE.
- Arithmetic:
  - Unsigned throughout.
  - bet=0 gives win_amount=0 with the class still reported.

Decomposition:
- Shared package, used by the bank and the VGA overlay:
  - class encodings (NONE..JACKPOT, INVALID=7)
  - multiplier constants 0/2/5/10/50/100
  - JACKPOT_DIGIT=7
  - state encodings
- One natural sub-module: payout_classify.
  - Combinational.
  - Inputs: the four latched digits.
  - Outputs: class and multiplier.
  - Instantiated once; the FSM, shift-add datapath and handshake stay in payout_eval.

Test Plan:
- Reels 7,7,7,7, bet=10, stop_pulse at edge N, win_ack held high → win_valid rises after edge N+8 for one cycle; win_class=5, win_amount=1000.
- Reels 3,3,5,5, bet=4, win_ack delayed 5 cycles → win_class=2, win_amount=20, held stable all 5 cycles; busy=1 from N+1 until the ack edge.
- Reels 1,2,3,4, bet=100 → win_class=0, win_amount=0, win_valid still asserted and the handshake completes.
- Reels 9,9,9,9, bet=2000 (BAL_W=16) → win_class=4, product 100000 saturates, win_amount=65535.
- Reel3=12 with the others 1,1,1 → win_class=7, win_amount=0.
- Boundary cases:
  - Second stop_pulse during MULT → ignored, only one payout is produced.
  - rst=0 during MULT → next cycle IDLE, win_valid=0, busy=0.
  - A fresh stop_pulse after reset → normal round with latency 8.
